// File: rtl/ibuf_prefetch.sv
// Instruction prefetch buffer: fetches 16-bit words into a 16-entry RAM and tracks the byte-level read pointer.
// Define IBUF_PREFETCH_LOOKAHEAD_EN to issue back-to-back requests while buffer space remains.
module ibuf_prefetch (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic [19:0] flush_addr,
  output logic        mem_req,
  output logic [18:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic        buf_we,
  output logic [3:0]  buf_waddr,
  output logic [15:0] buf_wdata,
  input  logic        consume,
  input  logic [2:0]  consume_len,
  output logic [4:0]  rd_ptr,
  output logic [5:0]  level
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DROP
  } state_t;

  state_t      state, state_nxt;
  logic [4:0]  fill_words, fill_nxt;
  logic [3:0]  wr_ptr;
  logic [18:0] fetch_addr;
  logic [18:0] mem_addr_nxt;
  logic        ack_take;
  logic        consume_ok;
  logic [1:0]  words_freed;
  logic        space_idle;

  // A flush to an odd address leaves no valid byte until the first word lands.
  assign level = (fill_words == 5'd0) ? 6'd0
               : ({fill_words, 1'b0} - {5'b0, rd_ptr[0]});

  assign mem_req     = (state == S_REQ) || (state == S_DROP);
  assign consume_ok  = consume && !flush && (consume_len != 3'd0) && (consume_len != 3'd7)
                       && ({3'b0, consume_len} <= level);
  assign words_freed = 2'(({2'b0, rd_ptr[0]} + consume_len) >> 1);
  assign space_idle  = ({1'b0, fill_words} + {5'b0, buf_we}) < 6'd16;
  assign fill_nxt    = fill_words + {4'b0, buf_we} - (consume_ok ? {3'b0, words_freed} : 5'd0);

`ifdef IBUF_PREFETCH_LOOKAHEAD_EN
  logic space_after_ack;
  // The word being acknowledged now is also counted as occupying a slot.
  assign space_after_ack = ({1'b0, fill_words} + {5'b0, buf_we} + 6'd1) < 6'd16;
`endif

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_nxt    = state;
    mem_addr_nxt = mem_addr;
    ack_take     = 1'b0;
    case (state)
      S_IDLE: begin
        if (!flush && space_idle) begin
          state_nxt    = S_REQ;
          mem_addr_nxt = fetch_addr;
        end
      end
      S_REQ: begin
        if (mem_ack) begin
          if (flush) begin
            state_nxt = S_IDLE;
          end else begin
            ack_take = 1'b1;
`ifdef IBUF_PREFETCH_LOOKAHEAD_EN
            if (space_after_ack) begin
              state_nxt    = S_REQ;
              mem_addr_nxt = fetch_addr + 19'd1;
            end else begin
              state_nxt = S_IDLE;
            end
`else
            state_nxt = S_IDLE;
`endif
          end
        end else if (flush) begin
          state_nxt = S_DROP;
        end
      end
      S_DROP: begin
        if (mem_ack) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: all state updates use non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      mem_addr   <= '0;
      buf_we     <= 1'b0;
      buf_waddr  <= '0;
      buf_wdata  <= '0;
      rd_ptr     <= '0;
      fill_words <= '0;
      wr_ptr     <= '0;
      fetch_addr <= '0;
    end else begin
      state    <= state_nxt;
      mem_addr <= mem_addr_nxt;
      buf_we   <= ack_take;
      if (ack_take) begin
        buf_waddr <= wr_ptr;
        buf_wdata <= mem_rdata;
      end
      if (flush) begin
        fill_words <= '0;
        wr_ptr     <= '0;
        rd_ptr     <= {4'b0, flush_addr[0]};
        fetch_addr <= flush_addr[19:1];
      end else begin
        fill_words <= fill_nxt;
        if (ack_take) begin
          wr_ptr     <= wr_ptr + 4'd1;
          fetch_addr <= fetch_addr + 19'd1;
        end
        if (consume_ok) rd_ptr <= rd_ptr + {2'b0, consume_len};
      end
    end
  end

endmodule

// File: tb/tb_ibuf_prefetch.sv
// Self-checking bench for ibuf_prefetch: directed scenarios followed by randomized traffic
// checked against a byte/word-count reference model.
module tb_ibuf_prefetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [19:0] flush_addr;
  logic        mem_req;
  logic [18:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        buf_we;
  logic [3:0]  buf_waddr;
  logic [15:0] buf_wdata;
  logic        consume;
  logic [2:0]  consume_len;
  logic [4:0]  rd_ptr;
  logic [5:0]  level;

`ifdef IBUF_PREFETCH_LOOKAHEAD_EN
  localparam int PERIOD = 1;
`else
  localparam int PERIOD = 2;
`endif

  ibuf_prefetch dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .flush_addr(flush_addr),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .buf_we(buf_we), .buf_waddr(buf_waddr), .buf_wdata(buf_wdata),
    .consume(consume), .consume_len(consume_len), .rd_ptr(rd_ptr), .level(level)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: words held in RAM, byte read position, pending write, next stream address.
  int          m_words, m_wptr, m_rdp;
  bit          m_pend;
  int          m_pwaddr;
  logic [15:0] m_pwdata;
  logic [18:0] m_fetch;
  bit          m_stale;
  int          ack_mode;
  int          cyc;
  int          ack_cyc[$];

  function automatic int m_level();
    return (m_words == 0) ? 0 : 2 * m_words - (m_rdp % 2);
  endfunction

  task automatic model_reset();
    m_words = 0; m_wptr = 0; m_rdp = 0; m_pend = 0;
    m_pwaddr = 0; m_pwdata = '0; m_fetch = '0; m_stale = 0;
  endtask

  task automatic model_step(input bit r, input bit hs);
    int lvl, dec, cl;
    lvl = m_level();
    dec = 0;
    cl  = int'(consume_len);
    if (flush) begin
      m_stale = r && !mem_ack;
      m_words = 0; m_wptr = 0; m_pend = 0;
      m_rdp   = int'(flush_addr[0]);
      m_fetch = flush_addr[19:1];
    end else begin
      if (consume && cl >= 1 && cl <= 6 && cl <= lvl) begin
        dec   = ((m_rdp % 2) + cl) / 2;
        m_rdp = (m_rdp + cl) % 32;
      end
      m_words = m_words + int'(m_pend) - dec;
      m_pend  = 0;
      if (hs) begin
        if (m_stale) m_stale = 0;
        else begin
          m_pend   = 1;
          m_pwaddr = m_wptr;
          m_pwdata = mem_rdata;
          m_wptr   = (m_wptr + 1) % 16;
          m_fetch  = m_fetch + 19'd1;
        end
      end
    end
  endtask

  task automatic check_outputs(input bit r_prev, input logic [18:0] ma_prev, input bit hs_prev);
    check("level", level, m_level());
    check("rd_ptr", rd_ptr, m_rdp);
    check("buf_we", buf_we, m_pend);
    if (m_pend) begin
      check("buf_waddr", buf_waddr, m_pwaddr);
      check("buf_wdata", buf_wdata, m_pwdata);
    end
    if (mem_req) begin
      if (r_prev && !hs_prev) check("addr_hold", mem_addr, ma_prev);
      else begin
        check("req_addr", mem_addr, m_fetch);
        check("req_space", (m_words + int'(m_pend)) < 16, 1);
      end
    end
  endtask

  // One clock: entered and left at a falling edge with inputs already driven.
  task automatic cycle();
    bit r, hs;
    logic [18:0] ma;
    case (ack_mode)
      1:       mem_ack = mem_req;
      2:       mem_ack = mem_req && ($urandom_range(0, 2) == 0);
      default: mem_ack = 1'b0;
    endcase
    mem_rdata = 16'($urandom);
    r  = mem_req;
    ma = mem_addr;
    hs = r && mem_ack;
    @(posedge clk);
    model_step(r, hs);
    cyc++;
    if (hs) ack_cyc.push_back(cyc);
    @(negedge clk);
    check_outputs(r, ma, hs);
  endtask

  task automatic wait_req(input string tag);
    for (int i = 0; i < 6 && !mem_req; i++) cycle();
    check(tag, mem_req, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int nreq;
    rst_n = 1'b0; flush = 1'b0; flush_addr = '0; mem_ack = 1'b0; mem_rdata = '0;
    consume = 1'b0; consume_len = '0; ack_mode = 0; cyc = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_buf_we", buf_we, 0);
    check("rst_buf_waddr", buf_waddr, 0);
    check("rst_buf_wdata", buf_wdata, 0);
    check("rst_rd_ptr", rd_ptr, 0);
    check("rst_level", level, 0);
    rst_n = 1'b1;

    // Ack tied to request, no consume: words 0..15 fill the buffer, then fetch stops.
    ack_mode = 1;
    ack_cyc.delete();
    for (int i = 0; i < 120 && level != 6'd32; i++) cycle();
    check("fill_level", level, 32);
    check("fill_acks", ack_cyc.size(), 16);
    if (ack_cyc.size() == 16) check("fill_span", ack_cyc[15] - ack_cyc[0], 15 * PERIOD);
    nreq = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (mem_req) nreq++;
    end
    check("full_no_req", nreq, 0);

    // Full buffer, consume 6 bytes from rd_ptr 0.
    ack_mode = 0;
    consume = 1'b1; consume_len = 3'd6;
    cycle();
    consume = 1'b0;
    check("c6_rd_ptr", rd_ptr, 6);
    check("c6_level", level, 26);
    wait_req("c6_refill_req");

    // Flush while the request waits for its ack.
    cycle();
    flush = 1'b1; flush_addr = 20'h01235;
    cycle();
    flush = 1'b0;
    check("drop_hold_req", mem_req, 1);
    cycle();
    ack_mode = 1;
    cycle();
    ack_mode = 0;
    check("drop_no_write", buf_we, 0);
    wait_req("flush_req");
    check("flush_req_addr", mem_addr, 19'h0091A);
    check("flush_rd_ptr", rd_ptr, 1);

    // First word after odd flush gives level 1; second gives level 3.
    ack_mode = 1; cycle(); ack_mode = 0;
    cycle(); cycle();
    check("first_level", level, 1);
    wait_req("second_req");
    ack_mode = 1; cycle(); ack_mode = 0;
    cycle(); cycle();
    check("second_level", level, 3);
    consume = 1'b1; consume_len = 3'd5;
    cycle();
    check("over_rd_ptr", rd_ptr, 1);
    check("over_level", level, 3);
    consume_len = 3'd0;
    cycle();
    check("len0_level", level, 3);
    consume_len = 3'd7;
    cycle();
    check("len7_rd_ptr", rd_ptr, 1);
    consume = 1'b0;

    // Reset in the middle of an outstanding request.
    wait_req("pre_rst_req");
    #2 rst_n = 1'b0;
    #1;
    check("midrst_mem_req", mem_req, 0);
    check("midrst_level", level, 0);
    check("midrst_rd_ptr", rd_ptr, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    wait_req("post_rst_req");
    check("post_rst_addr", mem_addr, 0);

    // Randomized traffic alternating fill-heavy and drain-heavy phases.
    ack_mode = 2;
    for (int i = 0; i < 4000; i++) begin
      flush       = ($urandom_range(0, 59) == 0);
      flush_addr  = 20'($urandom);
      consume     = ($urandom_range(0, 99) < (((i / 500) % 2) != 0 ? 60 : 10));
      consume_len = 3'($urandom_range(0, 7));
      cycle();
    end
    flush = 1'b0; consume = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ibuf_prefetch.md
IBUF_PREFETCH -- requirements
Module: ibuf_prefetch

Interface
REQ-001 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-003 SHALL have port flush  in  1  discard buffer, restart fetch at flush_addr.
REQ-004 SHALL have port flush_addr  in  20  linear byte address of new fetch stream.
REQ-005 SHALL have port mem_req  out  1  fetch request, held until mem_ack.
REQ-006 SHALL have port mem_addr  out  19  word address (byte address bits 19:1) of the fetch.
REQ-007 SHALL have port mem_ack  in  1  single-cycle completion; mem_rdata valid same cycle.
REQ-008 SHALL have port mem_rdata  in  16  fetched word, byte at even address in bits 7:0.
REQ-009 SHALL have ports buf_we  out  1, buf_waddr  out  4, buf_wdata  out  16: write port to the 16x16 instruction buffer RAM.
REQ-010 SHALL have port consume  in  1  decoder retires consume_len bytes this cycle.
REQ-011 SHALL have port consume_len  in  3  bytes retired, 1..6; 0 and 7 SHALL be treated as no-op.
REQ-012 SHALL have port rd_ptr  out  5  byte read pointer; bits 4:2 drive the buffer's 32-bit read address.
REQ-013 SHALL have port level  out  6  valid unconsumed bytes, 0..32.

Function
REQ-014 SHALL keep fill_words (0..16), wr_ptr (4 bits, wraps 15->0), rd_ptr (5 bits, wraps 31->0), fetch address (19 bits, wraps to 0).
REQ-015 SHALL drive level = 2*fill_words - rd_ptr[0] combinationally from registers.
REQ-016 SHALL implement states IDLE, REQ, DROP; mem_req high exactly in REQ and DROP.
REQ-017 IDLE->REQ when fill_words + pending_write < 16 and flush low; mem_addr = fetch address.
REQ-018 REQ on mem_ack: register buf_we=1, buf_waddr=wr_ptr, buf_wdata=mem_rdata for the next cycle only; increment wr_ptr and fetch address.
REQ-019 fill_words SHALL increment on the edge that ends the buf_we cycle, so level never counts a word before it is in RAM.
REQ-020 consume with consume_len <= level SHALL add consume_len to rd_ptr; fill_words decrements by the number of word boundaries crossed (0..3).
REQ-021 consume with consume_len > level SHALL be ignored entirely.
REQ-022 Simultaneous increment and decrement of fill_words SHALL net in one edge.
REQ-023 flush SHALL, next edge: fill_words=0, wr_ptr=0, rd_ptr={4'b0, flush_addr[0]}, fetch address=flush_addr[19:1], cancel any registered buf_we, ignore concurrent consume.
REQ-024 flush in REQ without mem_ack SHALL go to DROP; DROP holds mem_req and mem_addr until mem_ack, discards that data, then goes to IDLE.
REQ-025 flush coincident with mem_ack (REQ or DROP) SHALL discard the data and go to IDLE.
REQ-026 flush in IDLE or DROP SHALL leave the state unchanged apart from REQ-023.
REQ-027 mem_addr SHALL not change while mem_req is high.

Reset
REQ-028 rst_n low SHALL asynchronously force state IDLE, mem_req=0, mem_addr=0, buf_we=0, buf_waddr=0, buf_wdata=0, rd_ptr=0, fill_words=0, level=0, wr_ptr=0, fetch address=0.
REQ-029 Reset mid-bus-cycle SHALL abandon the request; the first request after reset SHALL be word 0 unless flush occurs.

Configuration
REQ-030 With IBUF_PREFETCH_LOOKAHEAD_EN defined, REQ on mem_ack SHALL stay in REQ with the next mem_addr when space remains (counting the pending write), giving back-to-back requests.
REQ-031 Without IBUF_PREFETCH_LOOKAHEAD_EN, REQ on mem_ack SHALL always go to IDLE, one idle cycle between requests.

Verification
REQ-032 Reset, mem_ack tied to mem_req, no consume -> mem_addr 0..15 in order, buf_waddr 0..15, level reaches 32, mem_req stays low after that.
REQ-033 flush_addr=20'h01235 -> first mem_addr=19'h0091A, rd_ptr=1, level=1 after first write.
REQ-034 Full buffer, consume len 6 at rd_ptr=0 -> rd_ptr=6, fill_words 16->13, level=26, new request issued.
REQ-035 flush while REQ waits 3 cycles for mem_ack -> mem_req held, ack data not written (buf_we stays 0), next request at flush address.
REQ-036 level=3, consume_len=5 -> no change to rd_ptr or level; consume_len=0 -> no-op.
REQ-037 With and without IBUF_PREFETCH_LOOKAHEAD_EN, zero-wait memory -> 16 words fill in 16 vs 32 cycles respectively (excluding the initial request cycle).
